// File: rtl/button_debounce.sv
// Pushbutton conditioner: synchronises a raw pin, qualifies transitions with a
// debounce counter, and emits a clean level, edge strobes, long-press strobe and press count.
//
// state       | meaning
// RELEASED    | accepted level is released, input agrees
// PRESS_CHK   | input reads pressed, counting stable samples before accepting
// PRESSED     | accepted level is pressed, long-press timer running
// RELEASE_CHK | input reads released, counting stable samples before accepting
module button_debounce #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 64,
  parameter int COUNT_WIDTH       = 8,
  parameter bit ACTIVE_LOW        = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_in,
  output logic                   btn_level,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic                   long_press_pulse,
  output logic [COUNT_WIDTH-1:0] press_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int LP_W = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_ONE  = LP_W'(1);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_PRESS_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   btn_s;

  state_t                 state, state_nxt;
  logic [DB_W-1:0]        db_cnt, db_cnt_nxt;
  logic [LP_W-1:0]        long_cnt, long_cnt_nxt;
  logic                   level_nxt;
  logic                   press_nxt;
  logic                   release_nxt;
  logic                   long_nxt;
  logic [COUNT_WIDTH-1:0] count_nxt;

  // Pin is normalised so that 1 always means pressed from here on.
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], btn_in ^ ACTIVE_LOW};
  end

  assign btn_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= RELEASED;
      db_cnt           <= '0;
      long_cnt         <= '0;
      btn_level        <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      press_count      <= '0;
    end else begin
      state            <= state_nxt;
      db_cnt           <= db_cnt_nxt;
      long_cnt         <= long_cnt_nxt;
      btn_level        <= level_nxt;
      press_pulse      <= press_nxt;
      release_pulse    <= release_nxt;
      long_press_pulse <= long_nxt;
      press_count      <= count_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    db_cnt_nxt   = db_cnt;
    long_cnt_nxt = long_cnt;
    level_nxt    = btn_level;
    press_nxt    = 1'b0;
    release_nxt  = 1'b0;
    long_nxt     = 1'b0;
    count_nxt    = press_count;

    // Long timer keeps running through release bounce; it only restarts on a new press.
    if ((state == PRESSED || state == RELEASE_CHK) && long_cnt != LP_MAX) begin
      long_cnt_nxt = long_cnt + LP_ONE;
      long_nxt     = (long_cnt == LP_LAST);
    end

    case (state)
      RELEASED: begin
        if (btn_s) begin
          state_nxt  = PRESS_CHK;
          db_cnt_nxt = DB_ONE;
        end
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_nxt  = RELEASED;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt    = PRESSED;
          db_cnt_nxt   = '0;
          level_nxt    = 1'b1;
          press_nxt    = 1'b1;
          count_nxt    = press_count + CNT_ONE;
          long_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + DB_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt  = RELEASE_CHK;
          db_cnt_nxt = DB_ONE;
        end
      end
      RELEASE_CHK: begin
        if (btn_s) begin
          state_nxt  = PRESSED;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt   = RELEASED;
          db_cnt_nxt  = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + DB_ONE;
        end
      end
      default: begin
        state_nxt  = RELEASED;
        db_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: four instances (defaults, narrow counter, active-low,
// short timings) checked every cycle against a run-length reference model.
module tb_button_debounce;

  typedef struct packed {
    logic [3:0] sync;
    int         level;
    int         run;
    int         age;
    int         count;
    logic       pp;
    logic       rp;
    logic       lp;
  } mdl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic btn0, btn1, btn2, btn3;

  logic       lvl0, pp0, rp0, lp0;
  logic [7:0] cnt0;
  logic       lvl1, pp1, rp1, lp1;
  logic [1:0] cnt1;
  logic       lvl2, pp2, rp2, lp2;
  logic [7:0] cnt2;
  logic       lvl3, pp3, rp3, lp3;
  logic [3:0] cnt3;

  button_debounce dut0 (
    .clk(clk), .rst(rst), .btn_in(btn0), .btn_level(lvl0), .press_pulse(pp0),
    .release_pulse(rp0), .long_press_pulse(lp0), .press_count(cnt0));

  button_debounce #(.COUNT_WIDTH(2)) dut1 (
    .clk(clk), .rst(rst), .btn_in(btn1), .btn_level(lvl1), .press_pulse(pp1),
    .release_pulse(rp1), .long_press_pulse(lp1), .press_count(cnt1));

  button_debounce #(.ACTIVE_LOW(1'b1)) dut2 (
    .clk(clk), .rst(rst), .btn_in(btn2), .btn_level(lvl2), .press_pulse(pp2),
    .release_pulse(rp2), .long_press_pulse(lp2), .press_count(cnt2));

  button_debounce #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(3), .LONG_PRESS_CYCLES(8),
                    .COUNT_WIDTH(4)) dut3 (
    .clk(clk), .rst(rst), .btn_in(btn3), .btn_level(lvl3), .press_pulse(pp3),
    .release_pulse(rp3), .long_press_pulse(lp3), .press_count(cnt3));

  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_n  = 0;
  mdl_t m0 = '0, m1 = '0, m2 = '0, m3 = '0;
  int   np0, nr0, nl0, np2, nr2, press_edge0, long_edge0;

  // Accepted level flips once DEB consecutive synchronised samples disagree with it;
  // long pulse fires when the time spent pressed reaches LNG.
  function automatic mdl_t mdl_step(mdl_t m, logic r_in, logic b, int ns, int deb,
                                    int lng, int cw);
    mdl_t r;
    logic s;
    r    = m;
    r.pp = 1'b0;
    r.rp = 1'b0;
    r.lp = 1'b0;
    if (r_in) begin
      r = '0;
      return r;
    end
    s = m.sync[ns-1];
    if (m.level == 1 && m.age < lng) begin
      r.age = m.age + 1;
      r.lp  = (r.age == lng);
    end
    if (int'(s) != m.level) begin
      r.run = m.run + 1;
      if (r.run == deb) begin
        r.run   = 0;
        r.level = int'(s);
        if (s) begin
          r.pp    = 1'b1;
          r.count = (m.count + 1) % (1 << cw);
          r.age   = 0;
        end else begin
          r.rp = 1'b1;
        end
      end
    end else begin
      r.run = 0;
    end
    r.sync = {m.sync[2:0], b};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string nm, input mdl_t m, input logic lvl, input logic pp,
                         input logic rp, input logic lp, input logic [31:0] cnt);
    chk($sformatf("%s level @%0d", nm, edge_n), {31'b0, lvl}, m.level);
    chk($sformatf("%s press @%0d", nm, edge_n), {31'b0, pp}, {31'b0, m.pp});
    chk($sformatf("%s release @%0d", nm, edge_n), {31'b0, rp}, {31'b0, m.rp});
    chk($sformatf("%s long @%0d", nm, edge_n), {31'b0, lp}, {31'b0, m.lp});
    chk($sformatf("%s count @%0d", nm, edge_n), cnt, m.count);
  endtask

  task automatic clr_stats();
    np0 = 0; nr0 = 0; nl0 = 0; np2 = 0; nr2 = 0;
    press_edge0 = -1; long_edge0 = -1;
  endtask

  // Drives pattern b for n cycles on dut0-2 (inverted for the active-low one); dut3 gets random toggles.
  task automatic run(input int n, input logic b);
    for (int i = 0; i < n; i++) begin
      btn0 = b;
      btn1 = b;
      btn2 = ~b;
      if ($urandom_range(5) == 0) btn3 = ~btn3;
      @(posedge clk);
      edge_n++;
      m0 = mdl_step(m0, rst, btn0, 2, 16, 64, 8);
      m1 = mdl_step(m1, rst, btn1, 2, 16, 64, 2);
      m2 = mdl_step(m2, rst, ~btn2, 2, 16, 64, 8);
      m3 = mdl_step(m3, rst, btn3, 3, 3, 8, 4);
      @(negedge clk);
      chk_dut("d0", m0, lvl0, pp0, rp0, lp0, {24'b0, cnt0});
      chk_dut("d1", m1, lvl1, pp1, rp1, lp1, {30'b0, cnt1});
      chk_dut("d2", m2, lvl2, pp2, rp2, lp2, {24'b0, cnt2});
      chk_dut("d3", m3, lvl3, pp3, rp3, lp3, {28'b0, cnt3});
      if (pp0 === 1'b1) begin np0++; press_edge0 = edge_n; end
      if (rp0 === 1'b1) nr0++;
      if (lp0 === 1'b1) begin nl0++; long_edge0 = edge_n; end
      if (pp2 === 1'b1) np2++;
      if (rp2 === 1'b1) nr2++;
    end
  endtask

  initial begin
    logic [1:0] wrap_exp [4];
    int e0;
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0};
    btn3 = 1'b0;
    rst  = 1'b1;
    clr_stats();
    run(3, 1'b0);
    rst = 1'b0;
    chk("reset level", {31'b0, lvl0}, 0);
    chk("reset press", {31'b0, pp0}, 0);
    chk("reset count", {24'b0, cnt0}, 0);

    // clean press and hold
    clr_stats();
    e0 = edge_n + 1;
    run(100, 1'b1);
    chk("clean press edge", press_edge0, e0 + 17);
    chk("clean press pulses", np0, 1);
    chk("clean level", {31'b0, lvl0}, 1);
    chk("clean count", {24'b0, cnt0}, 1);
    chk("clean long pulses", nl0, 1);
    chk("clean long delay", long_edge0 - press_edge0, 64);
    chk("active-low press pulses", np2, 1);
    run(30, 1'b0);
    chk("clean release pulses", nr0, 1);
    chk("active-low release pulses", nr2, 1);

    // bounce never qualifies
    clr_stats();
    run(10, 1'b1); run(3, 1'b0); run(5, 1'b1); run(30, 1'b0);
    chk("bounce press pulses", np0, 0);
    chk("bounce release pulses", nr0, 0);
    chk("bounce level", {31'b0, lvl0}, 0);
    chk("bounce count", {24'b0, cnt0}, 1);

    // release bounce while held
    clr_stats();
    run(40, 1'b1); run(5, 1'b0); run(60, 1'b1);
    chk("hold bounce release pulses", nr0, 0);
    chk("hold bounce level", {31'b0, lvl0}, 1);
    chk("hold bounce long pulses", nl0, 1);
    chk("hold bounce long delay", long_edge0 - press_edge0, 64);
    run(20, 1'b0);
    chk("hold final release pulses", nr0, 1);
    chk("hold final level", {31'b0, lvl0}, 0);

    // short press
    clr_stats();
    run(30, 1'b1); run(30, 1'b0);
    chk("short press pulses", np0, 1);
    chk("short release pulses", nr0, 1);
    chk("short long pulses", nl0, 0);

    // counter wrap on the 2-bit instance
    rst = 1'b1;
    run(1, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      run(25, 1'b1); run(25, 1'b0);
      chk($sformatf("wrap count %0d", k), {30'b0, cnt1}, {30'b0, wrap_exp[k]});
    end

    // reset while pressed and still held
    run(40, 1'b1);
    chk("pre-reset level", {31'b0, lvl0}, 1);
    rst = 1'b1;
    run(1, 1'b1);
    rst = 1'b0;
    chk("mid reset level", {31'b0, lvl0}, 0);
    chk("mid reset count", {24'b0, cnt0}, 0);
    chk("mid reset press", {31'b0, pp0}, 0);
    clr_stats();
    e0 = edge_n + 1;
    run(30, 1'b1);
    chk("re-press edge", press_edge0, e0 + 17);
    chk("re-press count", {24'b0, cnt0}, 1);
    run(30, 1'b0);

    // randomised segments
    for (int s = 0; s < 60; s++)
      run(int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Input-side counterpart to the counter-driven LED outputs: conditions a raw mechanical pushbutton into clean, single-clock events.
- Synchronises the asynchronous pin, then debounces it with a qualification counter.
- Produces a stable level, one-cycle press, release and long-press pulses, and a wrapping press counter.
- Sits between a board pin and any control logic (mode select, LED pattern stepping) in the clk domain.

Parameters:
- SYNC_STAGES, 2: synchroniser flop count, minimum 2.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples required to accept a transition, minimum 2.
- LONG_PRESS_CYCLES, 64: cycles after press acceptance at which long_press_pulse fires. Must exceed DEBOUNCE_CYCLES.
- COUNT_WIDTH, 8: width of press_count.
- ACTIVE_LOW, 0: 1 means btn_in is inverted before synchronising (pressed = pin low).

Ports:
- clk, in, 1: single clock, all logic on rising edge.
- rst, in, 1: synchronous, active-high reset.
- btn_in, in, 1: raw asynchronous button pin.
- btn_level, out, 1: debounced state, 1 = pressed.
- press_pulse, out, 1: one-cycle strobe on accepted press.
- release_pulse, out, 1: one-cycle strobe on accepted release.
- long_press_pulse, out, 1: one-cycle strobe, at most once per press.
- press_count, out, COUNT_WIDTH: number of accepted presses, modulo 2^COUNT_WIDTH.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Normalisation: btn_n = btn_in XOR ACTIVE_LOW, feeding a SYNC_STAGES flop chain. btn_s is the last flop output.
- Reset (rst=1 at a rising edge):
  - Sync flops go to 0 (normalised released).
  - State goes to RELEASED; debounce and long counters go to 0.
  - btn_level, press_pulse, release_pulse, long_press_pulse and press_count all go to 0.
  - rst overrides everything, including mid-debounce or mid-press.
  - A button held through reset is re-detected as a new press after full qualification.
- FSM states and transitions (one debounce counter, width clog2(DEBOUNCE_CYCLES)+1):
  - RELEASED: on btn_s=1, go to PRESS_CHK with counter=1.
  - PRESS_CHK, btn_s=0: return to RELEASED, counter cleared. This is a glitch; no outputs change.
  - PRESS_CHK, btn_s=1 and counter==DEBOUNCE_CYCLES-1: go to PRESSED. Same edge: btn_level<=1, press_pulse<=1, press_count<=press_count+1 (wraps to 0 at max), long counter<=0.
  - PRESS_CHK, btn_s=1 otherwise: counter increments.
  - PRESSED: on btn_s=0, go to RELEASE_CHK with counter=1.
  - RELEASE_CHK, btn_s=1: return to PRESSED, counter cleared. This is bounce; the long counter is not reset.
  - RELEASE_CHK, btn_s=0 and counter==DEBOUNCE_CYCLES-1: go to RELEASED. Same edge: btn_level<=0, release_pulse<=1.
  - RELEASE_CHK, btn_s=0 otherwise: counter increments.
- Latency: for btn_n stable at 1 from edge k, btn_level and press_pulse are high after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. This is edge k+17 with defaults; release is symmetric.
- Pulses:
  - All pulses are registered, high exactly one cycle, and 0 otherwise.
  - press_pulse and release_pulse are never high in the same cycle.
- Long press:
  - The long counter increments every cycle in PRESSED or RELEASE_CHK and saturates at LONG_PRESS_CYCLES.
  - long_press_pulse is high for the one cycle in which the counter reaches LONG_PRESS_CYCLES, i.e. LONG_PRESS_CYCLES cycles after press_pulse.
  - If the release is accepted before that point, no long pulse fires.
  - A long pulse and release_pulse in the same cycle are permitted.
- Flop budget: no combinational path from btn_in to any output; all outputs are flops.

Test Plan:
- Clean press: defaults, btn_in 0→1 held 100 cycles → press_pulse single cycle 18 edges after the change; btn_level=1; press_count=1; long_press_pulse single cycle exactly 64 cycles after press_pulse.
- Bounce rejection: btn_in high 10 cycles, low 3, high 5, low → no pulses, btn_level=0, press_count=0.
- Release bounce while held: after acceptance, btn_in low 5 cycles then high again → btn_level stays 1, no release_pulse. Long pulse still fires 64 cycles after press_pulse. Final release held 20 cycles → release_pulse once, btn_level=0.
- Short press: hold 30 cycles then release → press_pulse and release_pulse once each, no long_press_pulse.
- Counter wrap: COUNT_WIDTH=2, four qualified presses → press_count 1,2,3,0.
- Reset mid-press: assert rst for 1 cycle while PRESSED and held → all outputs 0 next cycle. Button still held → new press_pulse 18 edges after rst deasserts; press_count=1.
- ACTIVE_LOW=1: idle pin high, drive low 20 cycles → press_pulse once; pin high 20 cycles → release_pulse once.
